// File: rtl/fifo_sync.sv
// Single-clock FIFO with count-based full/empty, threshold flags,
// over/underflow pulses and selectable standard or first-word-fall-through read.
module fifo_sync #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_WR_EN,
    input  logic [DW-1:0] I_WR_DATA,
    input  logic          I_RD_EN,
    output logic [DW-1:0] O_RD_DATA,
    output logic          O_RD_VALID,
    output logic          O_FULL,
    output logic          O_AFULL,
    output logic          O_EMPTY,
    output logic          O_AEMPTY,
    output logic [AW:0]   O_COUNT,
    output logic          O_OVF,
    output logic          O_UDF
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LVL);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic full, empty, wr_acc, rd_acc;

    // Status is decoded purely from the registered occupancy.
    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == '0);
    assign wr_acc = I_WR_EN & ~full;
    assign rd_acc = I_RD_EN & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = I_WR_EN & full;
        udf_d    = I_RD_EN & empty;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is never reset; a write coinciding with reset is dropped.
    always_ff @(posedge I_CLK) begin
        if (wr_acc && !I_RST) mem[wr_ptr_q] <= I_WR_DATA;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DW-1:0] rd_data_q, rd_data_d;
            logic          rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_acc;
                if (rd_acc) rd_data_d = mem[rd_ptr_q];
            end

            always_ff @(posedge I_CLK) begin
                if (I_RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign O_RD_DATA  = rd_data_q;
            assign O_RD_VALID = rd_valid_q;
        end else begin : g_fwft
            // Head of queue is always on display; I_RD_EN acknowledges it.
            assign O_RD_DATA  = mem[rd_ptr_q];
            assign O_RD_VALID = ~empty;
        end
    endgenerate

    assign O_FULL   = full;
    assign O_EMPTY  = empty;
    assign O_AFULL  = (count_q >= AF_CNT);
    assign O_AEMPTY = (count_q <= AE_CNT);
    assign O_COUNT  = count_q;
    assign O_OVF    = ovf_q;
    assign O_UDF    = udf_q;

endmodule
